// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter.
// Holds the FSM state encoding and the data returned to a master on timeout.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_DAT = 16'hFFFF;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving two masters access to one shared slave, with ack timeout.
// Latency: request sampled in IDLE is on the slave bus next cycle; ack is returned combinationally.
// Backpressure: masters hold their request until ack; the slave stalls by withholding i_s_ack.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_cs,
    input  logic        i_m0_we,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_dat,
    output logic [15:0] o_m0_dat,
    output logic        o_m0_ack,
    input  logic        i_m1_cs,
    input  logic        i_m1_we,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_dat,
    output logic [15:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_s_cs,
    output logic        o_s_we,
    output logic [15:0] o_s_addr,
    output logic [15:0] o_s_dat,
    input  logic [15:0] i_s_dat,
    input  logic        i_s_ack,
    output logic        o_err
);

    localparam int               CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          g, g_nxt;
    logic          lst, lst_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          gnt_cs;
    logic          done;
    logic [15:0]   rdat;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
            g     <= 1'b0;
            lst   <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            lst   <= lst_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign gnt_cs = g ? i_m1_cs : i_m0_cs;

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        lst_nxt   = lst;
        cnt_nxt   = cnt;
        done      = 1'b0;
        rdat      = '0;
        o_s_cs    = 1'b0;
        o_s_we    = 1'b0;
        o_s_addr  = '0;
        o_s_dat   = '0;
        o_err     = 1'b0;

        case (state)
            IDLE: begin
                if (i_m0_cs || i_m1_cs) begin
                    state_nxt = BUSY;
                    g_nxt     = (i_m0_cs && i_m1_cs) ? ~lst : i_m1_cs;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!gnt_cs) begin
                    // Master withdrew: drop the slave request now, keep fairness pointer.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    o_s_cs   = 1'b1;
                    o_s_we   = g ? i_m1_we   : i_m0_we;
                    o_s_addr = g ? i_m1_addr : i_m0_addr;
                    o_s_dat  = g ? i_m1_dat  : i_m0_dat;
                    if (i_s_ack) begin
                        done = 1'b1;
                        rdat = i_s_dat;
                    end else if (cnt == CNT_LAST) begin
                        done  = 1'b1;
                        rdat  = TIMEOUT_DAT;
                        o_err = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                    if (done) begin
                        state_nxt = IDLE;
                        lst_nxt   = g;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        o_m0_ack = done & ~g;
        o_m0_dat = (done & ~g) ? rdat : 16'h0000;
        o_m1_ack = done & g;
        o_m1_dat = (done & g) ? rdat : 16'h0000;

        // Outputs are held quiet for the whole reset cycle, not just after the edge.
        if (!i_reset_n) begin
            o_s_cs   = 1'b0;
            o_s_we   = 1'b0;
            o_s_addr = '0;
            o_s_dat  = '0;
            o_err    = 1'b0;
            o_m0_ack = 1'b0;
            o_m0_dat = '0;
            o_m1_ack = 1'b0;
            o_m1_dat = '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: hand-written vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int TO = 15;

    typedef struct packed {
        logic        rst_n;
        logic        m0_cs;
        logic        m0_we;
        logic [15:0] m0_addr;
        logic [15:0] m0_dat;
        logic        m1_cs;
        logic        m1_we;
        logic [15:0] m1_addr;
        logic [15:0] m1_dat;
        logic        s_ack;
        logic [15:0] s_dat;
    } in_t;

    typedef struct packed {
        logic        s_cs;
        logic        s_we;
        logic [15:0] s_addr;
        logic [15:0] s_dat;
        logic        m0_ack;
        logic [15:0] m0_dat;
        logic        m1_ack;
        logic [15:0] m1_dat;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n, m0_cs, m0_we, m1_cs, m1_we, s_ack;
    logic [15:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;
    logic [15:0] m0_rdat, m1_rdat, s_addr, s_wdat;
    logic        m0_ack, m1_ack, s_cs, s_we, err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: whether a transaction is in flight, who owns it,
    // how many BUSY cycles it has lasted (including the current one), and who was last served.
    bit m_busy;
    int m_owner;
    int m_cycles;
    int m_last;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_m0_cs   (m0_cs),
        .i_m0_we   (m0_we),
        .i_m0_addr (m0_addr),
        .i_m0_dat  (m0_wdat),
        .o_m0_dat  (m0_rdat),
        .o_m0_ack  (m0_ack),
        .i_m1_cs   (m1_cs),
        .i_m1_we   (m1_we),
        .i_m1_addr (m1_addr),
        .i_m1_dat  (m1_wdat),
        .o_m1_dat  (m1_rdat),
        .o_m1_ack  (m1_ack),
        .o_s_cs    (s_cs),
        .o_s_we    (s_we),
        .o_s_addr  (s_addr),
        .o_s_dat   (s_wdat),
        .i_s_dat   (s_rdat),
        .i_s_ack   (s_ack),
        .o_err     (err)
    );

    function automatic in_t mk_in(logic rst, logic c0, logic w0, logic [15:0] a0, logic [15:0] d0,
                                  logic c1, logic w1, logic [15:0] a1, logic [15:0] d1,
                                  logic ack, logic [15:0] sd);
        in_t v;
        v = '{rst, c0, w0, a0, d0, c1, w1, a1, d1, ack, sd};
        return v;
    endfunction

    function automatic out_t mk_out(logic scs, logic swe, logic [15:0] sa, logic [15:0] sd,
                                    logic k0, logic [15:0] r0, logic k1, logic [15:0] r1, logic e);
        out_t o;
        o = '{scs, swe, sa, sd, k0, r0, k1, r1, e};
        return o;
    endfunction

    task automatic step(input in_t v, input out_t e, input string name);
        out_t got;
        @(negedge clk);
        reset_n = v.rst_n;
        m0_cs = v.m0_cs;  m0_we = v.m0_we;  m0_addr = v.m0_addr;  m0_wdat = v.m0_dat;
        m1_cs = v.m1_cs;  m1_we = v.m1_we;  m1_addr = v.m1_addr;  m1_wdat = v.m1_dat;
        s_ack = v.s_ack;  s_rdat = v.s_dat;
        #1;
        got = '{s_cs, s_we, s_addr, s_wdat, m0_ack, m0_rdat, m1_ack, m1_rdat, err};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (s_cs s_we s_addr s_dat m0_ack m0_dat m1_ack m1_dat err)",
                     name, got, e);
        end
    endtask

    function automatic out_t model_out(in_t v);
        out_t o;
        logic        cs, we;
        logic [15:0] a, d;
        o = '0;
        if (!v.rst_n || !m_busy) return o;
        cs = (m_owner == 1) ? v.m1_cs   : v.m0_cs;
        we = (m_owner == 1) ? v.m1_we   : v.m0_we;
        a  = (m_owner == 1) ? v.m1_addr : v.m0_addr;
        d  = (m_owner == 1) ? v.m1_dat  : v.m0_dat;
        if (!cs) return o;
        o.s_cs = 1'b1;  o.s_we = we;  o.s_addr = a;  o.s_dat = d;
        if (v.s_ack || m_cycles == TO) begin
            if (m_owner == 1) begin
                o.m1_ack = 1'b1;
                o.m1_dat = v.s_ack ? v.s_dat : 16'hFFFF;
            end else begin
                o.m0_ack = 1'b1;
                o.m0_dat = v.s_ack ? v.s_dat : 16'hFFFF;
            end
            o.err = !v.s_ack;
        end
        return o;
    endfunction

    task automatic model_adv(input in_t v);
        logic cs;
        if (!v.rst_n) begin
            m_busy = 0;  m_last = 1;  m_owner = 0;  m_cycles = 0;
        end else if (!m_busy) begin
            if (v.m0_cs || v.m1_cs) begin
                m_busy   = 1;
                m_owner  = (v.m0_cs && v.m1_cs) ? 1 - m_last : (v.m1_cs ? 1 : 0);
                m_cycles = 1;
            end
        end else begin
            cs = (m_owner == 1) ? v.m1_cs : v.m0_cs;
            if (!cs) begin
                m_busy = 0;
            end else if (v.s_ack || m_cycles == TO) begin
                m_busy = 0;
                m_last = m_owner;
            end else begin
                m_cycles++;
            end
        end
    endtask

    vec_t tbl[18];
    in_t  vin;
    out_t vexp;

    initial begin
        reset_n = 0;  m0_cs = 0;  m0_we = 0;  m0_addr = 0;  m0_wdat = 0;
        m1_cs = 0;  m1_we = 0;  m1_addr = 0;  m1_wdat = 0;  s_ack = 0;  s_rdat = 0;

        // ---- table: reset, m0 read, m1 write, round-robin tie ----
        tbl[0]  = '{mk_in(0, 0,0,16'h0,16'h0,       0,0,16'h0,16'h0,       0,16'h0),    '0};
        tbl[1]  = '{mk_in(1, 1,0,16'h0010,16'h0,    0,0,16'h0,16'h0,       1,16'h5555), '0};
        tbl[2]  = '{mk_in(1, 1,0,16'h0010,16'h0,    0,0,16'h0,16'h0,       0,16'h0),
                    mk_out(1,0,16'h0010,16'h0, 0,16'h0, 0,16'h0, 0)};
        tbl[3]  = tbl[2];
        tbl[4]  = '{mk_in(1, 1,0,16'h0010,16'h0,    0,0,16'h0,16'h0,       1,16'h1234),
                    mk_out(1,0,16'h0010,16'h0, 1,16'h1234, 0,16'h0, 0)};
        tbl[5]  = '{mk_in(1, 0,0,16'h0,16'h0,       0,0,16'h0,16'h0,       0,16'h0),    '0};
        tbl[6]  = '{mk_in(1, 0,0,16'h0,16'h0,       1,1,16'h8000,16'hBEEF, 0,16'h0),    '0};
        tbl[7]  = '{mk_in(1, 0,0,16'h0,16'h0,       1,1,16'h8000,16'hBEEF, 0,16'h0),
                    mk_out(1,1,16'h8000,16'hBEEF, 0,16'h0, 0,16'h0, 0)};
        tbl[8]  = '{mk_in(1, 0,0,16'h0,16'h0,       1,1,16'h8000,16'hBEEF, 1,16'h0000),
                    mk_out(1,1,16'h8000,16'hBEEF, 0,16'h0, 1,16'h0, 0)};
        tbl[9]  = tbl[5];
        tbl[10] = '{mk_in(1, 1,0,16'h0001,16'h0,    1,0,16'h0002,16'h0,    0,16'h0),    '0};
        tbl[11] = '{tbl[10].i, mk_out(1,0,16'h0001,16'h0, 0,16'h0, 0,16'h0, 0)};
        tbl[12] = '{mk_in(1, 1,0,16'h0001,16'h0,    1,0,16'h0002,16'h0,    1,16'hAAAA),
                    mk_out(1,0,16'h0001,16'h0, 1,16'hAAAA, 0,16'h0, 0)};
        tbl[13] = tbl[10];
        tbl[14] = '{mk_in(1, 1,0,16'h0001,16'h0,    1,0,16'h0002,16'h0,    1,16'hBBBB),
                    mk_out(1,0,16'h0002,16'h0, 0,16'h0, 1,16'hBBBB, 0)};
        tbl[15] = tbl[10];
        tbl[16] = '{mk_in(1, 1,0,16'h0001,16'h0,    1,0,16'h0002,16'h0,    1,16'hCCCC),
                    mk_out(1,0,16'h0001,16'h0, 1,16'hCCCC, 0,16'h0, 0)};
        tbl[17] = tbl[5];

        for (int i = 0; i < 18; i++) step(tbl[i].i, tbl[i].o, $sformatf("table[%0d]", i));

        // ---- timeout at the 15th BUSY cycle, then ack winning on that same cycle ----
        step(mk_in(0, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,16'h0), '0, "to_reset");
        vin = mk_in(1, 1,0,16'h0100,16'h0, 0,0,16'h0,16'h0, 0,16'h0);
        step(vin, '0, "to_idle");
        for (int k = 1; k <= TO; k++) begin
            vexp = mk_out(1,0,16'h0100,16'h0, (k == TO), (k == TO) ? 16'hFFFF : 16'h0, 0,16'h0, (k == TO));
            step(vin, vexp, $sformatf("timeout_cyc%0d", k));
        end
        step(vin, '0, "to_gap");
        for (int k = 1; k <= TO; k++) begin
            vin.s_ack = (k == TO);
            vin.s_dat = 16'h7777;
            vexp = mk_out(1,0,16'h0100,16'h0, (k == TO), (k == TO) ? 16'h7777 : 16'h0, 0,16'h0, 0);
            step(vin, vexp, $sformatf("ackwins_cyc%0d", k));
        end
        step(mk_in(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,16'h0), '0, "to_done");

        // ---- m0 aborts in its 2nd BUSY cycle; pending m1 is served next ----
        step(mk_in(0, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,16'h0), '0, "ab_reset");
        vin = mk_in(1, 1,0,16'h0A0A,16'h0, 1,0,16'h0B0B,16'h0, 0,16'h0);
        step(vin, '0, "ab_idle");
        step(vin, mk_out(1,0,16'h0A0A,16'h0, 0,16'h0, 0,16'h0, 0), "ab_busy1");
        vin.m0_cs = 0;
        vin.s_ack = 1;  vin.s_dat = 16'h4321;
        step(vin, '0, "ab_abort");
        vin.s_ack = 0;
        step(vin, '0, "ab_gap");
        step(vin, mk_out(1,0,16'h0B0B,16'h0, 0,16'h0, 0,16'h0, 0), "ab_m1_busy");
        vin.s_ack = 1;
        step(vin, mk_out(1,0,16'h0B0B,16'h0, 0,16'h0, 1,16'h4321, 0), "ab_m1_ack");

        // ---- reset mid-BUSY drops the transaction; first tie then goes to m0 ----
        vin = mk_in(1, 0,0,16'h0,16'h0, 1,0,16'h0C0C,16'h0, 0,16'h0);
        step(vin, '0, "rs_idle");
        step(vin, mk_out(1,0,16'h0C0C,16'h0, 0,16'h0, 0,16'h0, 0), "rs_busy");
        vin.rst_n = 0;  vin.s_ack = 1;
        step(vin, '0, "rs_in_reset");
        vin = mk_in(1, 1,0,16'h0D0D,16'h0, 1,0,16'h0C0C,16'h0, 0,16'h0);
        step(vin, '0, "rs_after");
        step(vin, mk_out(1,0,16'h0D0D,16'h0, 0,16'h0, 0,16'h0, 0), "rs_tie_m0");

        // ---- randomized traffic against the reference model ----
        vin = '0;
        step(vin, '0, "rnd_reset");
        model_adv(vin);
        for (int n = 0; n < 3000; n++) begin
            int ackpct;
            ackpct = ((n / 300) % 3 == 0) ? 3 : 30;
            vin.rst_n   = ($urandom_range(0, 199) != 0);
            vin.m0_cs   = ($urandom_range(0, 99) < 70);
            vin.m1_cs   = ($urandom_range(0, 99) < 70);
            vin.m0_we   = 1'($urandom);
            vin.m1_we   = 1'($urandom);
            vin.m0_addr = 16'($urandom);
            vin.m1_addr = 16'($urandom);
            vin.m0_dat  = 16'($urandom);
            vin.m1_dat  = 16'($urandom);
            vin.s_ack   = ($urandom_range(0, 99) < ackpct);
            vin.s_dat   = 16'($urandom);
            step(vin, model_out(vin), $sformatf("random[%0d]", n));
            model_adv(vin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
